rep_code_tx: RTL

Repetition-code serial transmitter: accepts a parallel word over a valid/ready handshake and emits it LSB-first on a single serial line, each bit repeated REPEAT consecutive beats. It is the transmit end of the team's triple-redundancy link, whose receive end majority-votes each group of three copies back to one bit. It sits between the word producer and the serial channel, with backpressure from the channel.

---
 rtl/rep_code_tx_pkg.sv | 26 ++
 rtl/rep_code_tx_if.sv | 33 +++
 rtl/rep_code_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/rep_code_tx_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rep_code_tx_pkg : shared types/constants for the repetition link  |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package rep_code_tx_pkg;

  // Defaults shared with the majority-vote receiver on the far end.
  localparam int DATA_W_DEF = 8;
  localparam int REPEAT_DEF = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BIT_CNT_W_DEF = cnt_width(DATA_W_DEF);
  localparam int REP_CNT_W_DEF = cnt_width(REPEAT_DEF);

endpackage
`default_nettype wire

// File: rtl/rep_code_tx_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rep_code_tx_if : word-in / serial-beat-out handshake bundle       |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface rep_code_tx_if
  import rep_code_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_first;
  logic              tx_last;
  logic              busy;

  // master: the transmitter; slave: producer plus serial channel.
  modport master (
    input  in_data, in_valid, tx_ready,
    output in_ready, tx_bit, tx_valid, tx_first, tx_last, busy
  );

  modport slave (
    output in_data, in_valid, tx_ready,
    input  in_ready, tx_bit, tx_valid, tx_first, tx_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/rep_code_tx.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rep_code_tx : repetition-code serial transmitter, LSB first,      |
// |               each bit sent REPEAT times.            rev 1.0      |
// +-------------------------------------------------------------------+
module rep_code_tx
  import rep_code_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REPEAT = REPEAT_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst,
  rep_code_tx_if.master bus
);

  localparam int BIT_W = cnt_width(DATA_W);
  localparam int REP_W = cnt_width(REPEAT);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nx;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_cnt_nx;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_nx;

  logic send;
  logic rep_end;
  logic bit_end;
  logic beat;
  logic frame_end;
  logic ready;
  logic accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      sh      <= sh_nx;
      rep_cnt <= rep_cnt_nx;
      bit_cnt <= bit_cnt_nx;
    end
  end

  always_comb begin
    send      = (state == SEND);
    rep_end   = (rep_cnt == REP_LAST);
    bit_end   = (bit_cnt == BIT_LAST);
    beat      = send & bus.tx_ready;
    frame_end = beat & rep_end & bit_end;

    // Integrator note: in_ready depends combinationally on tx_ready (and rst)
    // so a new word can be taken on the final beat without an idle gap.
    ready  = ~rst & (~send | frame_end);
    accept = ready & bus.in_valid;

    state_nx   = state;
    sh_nx      = sh;
    rep_cnt_nx = rep_cnt;
    bit_cnt_nx = bit_cnt;

    if (beat) begin
      if (rep_end) begin
        rep_cnt_nx = '0;
        sh_nx      = sh >> 1;
        bit_cnt_nx = bit_cnt + 1'b1;
      end else begin
        rep_cnt_nx = rep_cnt + 1'b1;
      end
    end

    if (frame_end) begin
      state_nx   = IDLE;
      bit_cnt_nx = '0;
    end

    // A word accepted on the last beat reloads in place and keeps SEND.
    if (accept) begin
      state_nx   = SEND;
      sh_nx      = bus.in_data;
      rep_cnt_nx = '0;
      bit_cnt_nx = '0;
    end

    bus.in_ready = ready;
    bus.tx_valid = send;
    bus.busy     = send;
    bus.tx_bit   = send & sh[0];
    bus.tx_first = send & (rep_cnt == '0);
    bus.tx_last  = send & rep_end & bit_end;
  end

endmodule
`default_nettype wire
